// File: rtl/stereo_sample_fifo.sv
// Stereo sample FIFO: captures one {left,right} word per I2S frame
// and presents it first-word fall-through with drop accounting.
module stereo_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [5:0]    frame_posn,
  input  logic [15:0]   left,
  input  logic [15:0]   right,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drops,
  input  logic          clr_ovf
);

  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [AW:0] LVL_FULL = DEPTH_U[AW:0];

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [5:0]    prev_posn;

  logic strobe;
  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  // Rising into frame position 0 marks exactly one capture per frame.
  assign strobe = (frame_posn == 6'd0) && (prev_posn != 6'd0);
  assign full   = (level == LVL_FULL);
  assign pop    = out_valid && out_ready;
  assign wr_en  = strobe && (!full || pop);
  assign drop   = strobe && full && !pop;

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge ck) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= {left, right};
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      drops     <= 8'd0;
      prev_posn <= 6'd0;
    end else begin
      prev_posn <= frame_posn;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A drop coinciding with a clear restarts the count at one.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf) begin
          drops <= 8'd1;
        end else if (drops != 8'hff) begin
          drops <= drops + 8'd1;
        end
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drops    <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Bench for stereo_sample_fifo: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_stereo_sample_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          ck;
  logic          rst;
  logic [5:0]    frame_posn;
  logic [15:0]   left;
  logic [15:0]   right;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;
  logic          overflow;
  logic [7:0]    drops;
  logic          clr_ovf;

  stereo_sample_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .ck(ck),
    .rst(rst),
    .frame_posn(frame_posn),
    .left(left),
    .right(right),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .overflow(overflow),
    .drops(drops),
    .clr_ovf(clr_ovf)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mq[$];
  logic [5:0]  m_prev = 6'd0;
  bit          m_ovf  = 1'b0;
  int          m_drops = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input bit r, input logic [5:0] fp,
                      input logic [15:0] l, input logic [15:0] rt,
                      input bit rdy, input bit clr);
    bit strobe;
    bit pop;
    bit drop;
    int sz;
    rst = r;
    frame_posn = fp;
    left = l;
    right = rt;
    out_ready = rdy;
    clr_ovf = clr;
    sz = mq.size();
    strobe = (fp == 6'd0) && (m_prev != 6'd0);
    pop = (sz != 0) && rdy;
    if (r) begin
      mq.delete();
      m_prev = 6'd0;
      m_ovf = 1'b0;
      m_drops = 0;
    end else begin
      drop = strobe && (sz == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (strobe && !drop) mq.push_back({l, rt});
      if (drop) begin
        m_ovf = 1'b1;
        m_drops = clr ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
      end else if (clr) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
      m_prev = fp;
    end
    @(posedge ck);
    #1;
    chk("m_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("m_level", {27'd0, level}, mq.size());
    chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
    chk("m_drops", {24'd0, drops}, m_drops);
    if (mq.size() != 0) chk("m_data", out_data, mq[0]);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] rt,
                       input bit rdy, input bit clr);
    step(1'b0, 6'd63, 16'h0, 16'h0, rdy, 1'b0);
    step(1'b0, 6'd0, l, rt, rdy, clr);
  endtask

  typedef struct {
    bit          r;
    logic [5:0]  fp;
    logic [15:0] l;
    logic [15:0] rt;
    bit          rdy;
    bit          clr;
    bit          e_valid;
    logic [31:0] e_data;
    int          e_level;
    bit          e_ovf;
    int          e_drops;
  } vec_t;

  vec_t vt[9];

  initial begin
    int k;
    rst = 1'b1;
    frame_posn = 6'd0;
    left = 16'h0;
    right = 16'h0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;

    // Single capture, hold at 0, then pop and idle ready.
    vt[0] = '{1'b1, 6'd63, 16'h0, 16'h0, 1'b0, 1'b0,
              1'b0, 32'h0, 0, 1'b0, 0};
    vt[1] = '{1'b0, 6'd63, 16'h0, 16'h0, 1'b0, 1'b0,
              1'b0, 32'h0, 0, 1'b0, 0};
    vt[2] = '{1'b0, 6'd0, 16'h8234, 16'h8235, 1'b0, 1'b0,
              1'b1, 32'h82348235, 1, 1'b0, 0};
    vt[3] = '{1'b0, 6'd0, 16'h1111, 16'h2222, 1'b0, 1'b0,
              1'b1, 32'h82348235, 1, 1'b0, 0};
    vt[4] = '{1'b0, 6'd0, 16'h3333, 16'h4444, 1'b0, 1'b0,
              1'b1, 32'h82348235, 1, 1'b0, 0};
    vt[5] = '{1'b0, 6'd0, 16'h5555, 16'h6666, 1'b0, 1'b0,
              1'b1, 32'h82348235, 1, 1'b0, 0};
    vt[6] = '{1'b0, 6'd5, 16'h0, 16'h0, 1'b1, 1'b0,
              1'b0, 32'h0, 0, 1'b0, 0};
    vt[7] = '{1'b0, 6'd5, 16'h0, 16'h0, 1'b1, 1'b1,
              1'b0, 32'h0, 0, 1'b0, 0};
    vt[8] = '{1'b0, 6'd0, 16'hbeef, 16'hcafe, 1'b1, 1'b0,
              1'b1, 32'hbeefcafe, 1, 1'b0, 0};

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].fp, vt[i].l, vt[i].rt, vt[i].rdy, vt[i].clr);
      chk("t_valid", {31'd0, out_valid}, {31'd0, vt[i].e_valid});
      chk("t_level", {27'd0, level}, vt[i].e_level);
      chk("t_ovf", {31'd0, overflow}, {31'd0, vt[i].e_ovf});
      chk("t_drops", {24'd0, drops}, vt[i].e_drops);
      if (vt[i].e_valid) chk("t_data", out_data, vt[i].e_data);
    end

    // Fill and overflow, then drain in order.
    step(1'b1, 6'd5, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) frame(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0, 1'b0);
    chk("fill_level", {27'd0, level}, 16);
    chk("fill_ovf", {31'd0, overflow}, 1);
    chk("fill_drops", {24'd0, drops}, 2);
    for (int i = 0; i < 16; i++) begin
      chk("drain_word", out_data, {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
      step(1'b0, 6'd5, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", {31'd0, out_valid}, 0);

    // Full with simultaneous pop.
    step(1'b1, 6'd5, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) frame(16'h3000 + 16'(i), 16'h4000 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 6'd63, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 16'h7777, 16'h8888, 1'b1, 1'b0);
    chk("fullpop_level", {27'd0, level}, 16);
    chk("fullpop_drops", {24'd0, drops}, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 6'd5, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("fullpop_last", out_data, 32'h77778888);
    step(1'b0, 6'd5, 16'h0, 16'h0, 1'b1, 1'b0);

    // Pointer wrap with continuous ready.
    step(1'b1, 6'd5, 16'h0, 16'h0, 1'b0, 1'b0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 6'd63, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("wrap_lvl_a", {31'd0, level <= 1}, 1);
      step(1'b0, 6'd0, 16'h5000 + 16'(i), 16'h6000 + 16'(i), 1'b1, 1'b0);
      chk("wrap_lvl_b", {31'd0, level <= 1}, 1);
      if (out_valid && out_data == {16'h5000 + 16'(i), 16'h6000 + 16'(i)}) k++;
    end
    chk("wrap_seen", k, 40);
    chk("wrap_ovf", {31'd0, overflow}, 0);

    // Clear versus drop.
    step(1'b1, 6'd5, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) frame(16'(i), 16'(i), 1'b0, 1'b0);
    chk("clr_pre", {24'd0, drops}, 5);
    frame(16'haaaa, 16'hbbbb, 1'b0, 1'b1);
    chk("clr_drop_ovf", {31'd0, overflow}, 1);
    chk("clr_drop_cnt", {24'd0, drops}, 1);
    step(1'b0, 6'd5, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_ovf", {31'd0, overflow}, 0);
    chk("clr_cnt", {24'd0, drops}, 0);

    // Reset mid-stream while frame_posn holds 0.
    step(1'b1, 6'd5, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) frame(16'h9000 + 16'(i), 16'h0, 1'b0, 1'b0);
    chk("rst_pre", {27'd0, level}, 7);
    step(1'b1, 6'd0, 16'h1, 16'h1, 1'b0, 1'b0);
    chk("rst_level", {27'd0, level}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'd0, 16'h2, 16'h2, 1'b0, 1'b0);
      chk("rst_hold", {27'd0, level}, 0);
    end
    step(1'b0, 6'd9, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 16'habcd, 16'hef01, 1'b0, 1'b0);
    chk("rst_resume", {27'd0, level}, 1);

    // Random traffic with varying consumer rate.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [5:0] fp;
        bit rdy;
        fp = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        rdy = ($urandom_range(0, 3) < p + 1) && ($urandom_range(0, 1) == 1 || p == 2);
        step($urandom_range(0, 499) == 0, fp, 16'($urandom), 16'($urandom),
             rdy, $urandom_range(0, 49) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
